data_mem_resp: RTL



---
 rtl/data_mem_if.sv | 22 ++
 rtl/data_mem_resp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Load/store request and response bus between the execute stage and the data-memory responder.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_ctrl, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_ctrl, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: byte-lane stores into a word array, sign/zero-extended loads,
// alignment and funct3 legality checking, one-cycle response pulse.
module data_mem_resp #(
  parameter int unsigned WORD_ADDR_BITS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** WORD_ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_RESP      = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  ctrl_q, ctrl_d;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_word_q;

  logic                      accept_c;
  logic                      legal_c;
  logic                      misaligned_c;
  logic                      mem_we_c;
  logic                      mem_re_c;
  logic [3:0]                be_c;
  logic [31:0]               wdata_c;
  logic [WORD_ADDR_BITS-1:0] word_idx_c;
  logic [7:0]                byte_c;
  logic [15:0]               half_c;
  logic [31:0]               load_ext_c;
  logic                      unused_addr_c;

  assign accept_c      = bus.req_valid && ready_q;
  assign word_idx_c    = bus.req_addr[WORD_ADDR_BITS+1:2];
  // Upper address bits are deliberately ignored so addresses alias.
  assign unused_addr_c = ^bus.req_addr[31:WORD_ADDR_BITS+2];

  // Legality of the funct3 code for the requested direction.
  always_comb begin
    legal_c = 1'b0;
    if (bus.req_write) begin
      case (bus.req_ctrl)
        3'b000, 3'b001, 3'b010: legal_c = 1'b1;
        default:                legal_c = 1'b0;
      endcase
    end else begin
      case (bus.req_ctrl)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_c = 1'b1;
        default:                                legal_c = 1'b0;
      endcase
    end
  end

  // Size is funct3[1:0]; byte accesses are always aligned.
  always_comb begin
    misaligned_c = 1'b0;
    case (bus.req_ctrl[1:0])
      2'b01:   misaligned_c = bus.req_addr[0];
      2'b10:   misaligned_c = |bus.req_addr[1:0];
      default: misaligned_c = 1'b0;
    endcase
  end

  // Store lane enables with the right-aligned data replicated across all lanes.
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = bus.req_wdata;
    case (bus.req_ctrl[1:0])
      2'b00: begin
        be_c    = 4'(4'b0001 << bus.req_addr[1:0]);
        wdata_c = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = bus.req_wdata;
      end
    endcase
  end

  // Lane extraction and extension of the word read at the accept edge.
  always_comb begin
    byte_c = rd_word_q[7:0];
    case (lane_q)
      2'd0:    byte_c = rd_word_q[7:0];
      2'd1:    byte_c = rd_word_q[15:8];
      2'd2:    byte_c = rd_word_q[23:16];
      default: byte_c = rd_word_q[31:24];
    endcase
    half_c = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (ctrl_q)
      3'b000:  load_ext_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_ext_c = {{16{half_c[15]}}, half_c};
      3'b100:  load_ext_c = {24'd0, byte_c};
      3'b101:  load_ext_c = {16'd0, half_c};
      default: load_ext_c = rd_word_q;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    lane_d   = lane_q;
    ctrl_d   = ctrl_q;
    mem_we_c = 1'b0;
    mem_re_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (!legal_c || misaligned_c) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else if (bus.req_write) begin
            mem_we_c = 1'b1;
            state_d  = S_RESP;
            err_d    = 1'b0;
            rdata_d  = 32'd0;
          end else begin
            mem_re_c = 1'b1;
            lane_d   = bus.req_addr[1:0];
            ctrl_d   = bus.req_ctrl;
            state_d  = S_LOAD_WAIT;
          end
        end
      end
      S_LOAD_WAIT: begin
        rdata_d = load_ext_c;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      lane_q  <= 2'd0;
      ctrl_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      lane_q  <= lane_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Storage array and its read register are not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) begin
          mem_q[word_idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
        end
      end
    end
    if (mem_re_c) begin
      rd_word_q <= mem_q[word_idx_c];
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
